// File: rtl/multimode_reg_gl_pkg.sv
// Mode encodings shared by the multimode register and the controllers that drive it.
package multimode_reg_gl_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_INC  = 3'b100;
    localparam logic [2:0] MODE_DEC  = 3'b101;
    localparam logic [2:0] MODE_ROTL = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

endpackage

// File: rtl/multimode_bit_cell.sv
// One bit of the multimode register: a flop plus its 8:1 next-state mux.
module multimode_bit_cell
    import multimode_reg_gl_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] mode,
    input  logic       q_self,
    input  logic       d,
    input  logic       left,
    input  logic       left_rot,
    input  logic       right,
    input  logic       sum,
    output logic       q
);

    logic next;

    // Select the next value of this bit from the mode.
    // left carries sin into bit 0 for SHL; left_rot carries the MSB into bit 0 for ROTL.
    always_comb begin
        next = q_self;
        unique case (mode)
            MODE_HOLD: next = q_self;
            MODE_LOAD: next = d;
            MODE_SHL:  next = left;
            MODE_SHR:  next = right;
            MODE_INC:  next = sum;
            MODE_DEC:  next = sum;
            MODE_ROTL: next = left_rot;
            MODE_CLR:  next = 1'b0;
            default:   next = q_self;
        endcase
    end

    // Bit flop: reset wins, otherwise update only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_BIT;
        end else if (en) begin
            q <= next;
        end
    end

endmodule

// File: rtl/multimode_reg_gl.sv
// N-bit multimode register built from per-bit cells, a ripple inc/dec chain,
// a registered carry/shift-out flag and a zero detector.
module multimode_reg_gl
    import multimode_reg_gl_pkg::*;
#(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             zero
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] left_w;
    logic [WIDTH-1:0] rot_w;
    logic [WIDTH-1:0] right_w;
    logic             wrap;

    // Shared ripple chain: increment for INC, decrement for DEC (mode[0] selects).
    // A bit propagates when it is 1 (inc) or 0 (dec); the final carry flags the wrap.
    always_comb begin
        logic c;
        c = 1'b1;
        sum = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i] = q[i] ^ c;
            c      = (q[i] ^ mode[0]) & c;
        end
        wrap = c;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign left_w[i] = sin;
            assign rot_w[i]  = q[WIDTH-1];
        end else begin : g_mid_lo
            assign left_w[i] = q[i-1];
            assign rot_w[i]  = q[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign right_w[i] = sin;
        end else begin : g_mid_hi
            assign right_w[i] = q[i+1];
        end

        multimode_bit_cell #(
            .RESET_BIT(RESET_VALUE[i])
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .mode     (mode),
            .q_self   (q[i]),
            .d        (d[i]),
            .left     (left_w[i]),
            .left_rot (rot_w[i]),
            .right    (right_w[i]),
            .sum      (sum[i]),
            .q        (q[i])
        );
    end

    // Carry/shift-out flag: captures the bit leaving the register or the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cout <= 1'b0;
        end else if (en) begin
            unique case (mode)
                MODE_HOLD: cout <= cout;
                MODE_LOAD: cout <= 1'b0;
                MODE_SHL:  cout <= q[WIDTH-1];
                MODE_SHR:  cout <= q[0];
                MODE_INC:  cout <= wrap;
                MODE_DEC:  cout <= wrap;
                MODE_ROTL: cout <= q[WIDTH-1];
                MODE_CLR:  cout <= 1'b0;
                default:   cout <= cout;
            endcase
        end
    end

    assign zero = ~|q;

endmodule

// File: tb/tb_multimode_reg_gl.sv
// Self-checking bench for multimode_reg_gl: directed vector table plus a
// randomized run against a behavioural model, results via an expect queue.
module tb_multimode_reg_gl;
    import multimode_reg_gl_pkg::*;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       sin;
        logic [7:0] exp_q;
        logic       exp_cout;
        logic       exp_zero;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       cout;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = MODE_HOLD;
    logic [7:0] d = '0;
    logic       sin = 1'b0;
    logic [7:0] q, q0;
    logic       cout, cout0, zero, zero0;

    int n_vec  = 0;
    int n_fail = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    multimode_reg_gl #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q), .cout(cout), .zero(zero)
    );

    multimode_reg_gl #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q0), .cout(cout0), .zero(zero0)
    );

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                                input logic [7:0] dd, input logic s,
                                input logic [7:0] eq, input logic ec, input logic ez);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.d = dd; v.sin = s;
        v.exp_q = eq; v.exp_cout = ec; v.exp_zero = ez;
        return v;
    endfunction

    // Drive one vector before the edge, queue its expectation, check after the edge.
    task automatic apply(input vec_t v, input string name);
        exp_t e, got;
        rst = v.rst; en = v.en; mode = v.mode; d = v.d; sin = v.sin;
        e.q = v.exp_q; e.cout = v.exp_cout; e.zero = v.exp_zero;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_vec++;
        if (q !== got.q || cout !== got.cout || zero !== got.zero) begin
            n_fail++;
            $display("FAIL %s: got q=%h cout=%b zero=%b, expected q=%h cout=%b zero=%b",
                     name, q, cout, zero, got.q, got.cout, got.zero);
        end
    endtask

    initial begin
        logic [7:0] mq;
        logic       mc;
        logic [8:0] t9;
        vec_t       v;

        // 1: reset overrides a load
        tbl.push_back(mk(1, 1, MODE_LOAD, 8'hFF, 1, 8'hA5, 0, 0));
        // 2: load then en=0 for every mode
        tbl.push_back(mk(0, 1, MODE_LOAD, 8'h3C, 0, 8'h3C, 0, 0));
        for (int m = 0; m < 8; m++)
            tbl.push_back(mk(0, 0, 3'(m), 8'hFF, 1, 8'h3C, 0, 0));
        // 3: shifts and rotate
        tbl.push_back(mk(0, 1, MODE_LOAD, 8'h81, 0, 8'h81, 0, 0));
        tbl.push_back(mk(0, 1, MODE_SHL,  8'h00, 0, 8'h02, 1, 0));
        tbl.push_back(mk(0, 1, MODE_SHR,  8'h00, 1, 8'h81, 0, 0));
        tbl.push_back(mk(0, 1, MODE_ROTL, 8'h00, 0, 8'h03, 1, 0));
        // en=0 must also hold a set cout
        tbl.push_back(mk(0, 0, MODE_LOAD, 8'h55, 0, 8'h03, 1, 0));
        // 4: increment wrap, decrement borrow, HOLD keeps cout, CLR
        tbl.push_back(mk(0, 1, MODE_LOAD, 8'hFE, 0, 8'hFE, 0, 0));
        tbl.push_back(mk(0, 1, MODE_INC,  8'h00, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 1, MODE_INC,  8'h00, 0, 8'h00, 1, 1));
        tbl.push_back(mk(0, 1, MODE_DEC,  8'h00, 0, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 1, MODE_HOLD, 8'h00, 1, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 1, MODE_CLR,  8'hAA, 1, 8'h00, 0, 1));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // 1b: the RESET_VALUE=0 build after a fresh reset
        v = mk(1, 1, MODE_LOAD, 8'hFF, 0, 8'hA5, 0, 0);
        apply(v, "reset_a5");
        n_vec++;
        if (q0 !== 8'h00 || zero0 !== 1'b1 || cout0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_zero_build: got q=%h zero=%b cout=%b, expected q=00 zero=1 cout=0",
                     q0, zero0, cout0);
        end

        // 5: counting interrupted by reset, then resumes from RESET_VALUE
        apply(mk(0, 1, MODE_LOAD, 8'h10, 0, 8'h10, 0, 0), "cnt_load");
        apply(mk(0, 1, MODE_INC,  8'h00, 0, 8'h11, 0, 0), "cnt_inc1");
        apply(mk(0, 1, MODE_INC,  8'h00, 0, 8'h12, 0, 0), "cnt_inc2");
        apply(mk(1, 1, MODE_INC,  8'h00, 0, 8'hA5, 0, 0), "cnt_rst");
        apply(mk(0, 1, MODE_INC,  8'h00, 0, 8'hA6, 0, 0), "cnt_resume");

        // 6: random traffic against a behavioural model
        mq = 8'hA6;
        mc = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            v.rst  = ($urandom_range(63) == 0);
            v.en   = ($urandom_range(3) != 0);
            v.mode = 3'($urandom_range(7));
            v.d    = 8'($urandom);
            v.sin  = 1'($urandom);
            if (v.rst) begin
                mq = 8'hA5; mc = 1'b0;
            end else if (v.en) begin
                case (v.mode)
                    MODE_LOAD: begin mq = v.d; mc = 1'b0; end
                    MODE_SHL:  begin mc = mq[7]; mq = {mq[6:0], v.sin}; end
                    MODE_SHR:  begin mc = mq[0]; mq = {v.sin, mq[7:1]}; end
                    MODE_INC:  begin t9 = {1'b0, mq} + 9'd1; mq = t9[7:0]; mc = t9[8]; end
                    MODE_DEC:  begin t9 = {1'b0, mq} - 9'd1; mq = t9[7:0]; mc = t9[8]; end
                    MODE_ROTL: begin mc = mq[7]; mq = {mq[6:0], mq[7]}; end
                    MODE_CLR:  begin mq = 8'h00; mc = 1'b0; end
                    default:   ;
                endcase
            end
            v.exp_q = mq;
            v.exp_cout = mc;
            v.exp_zero = (mq == 8'h00);
            apply(v, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
